uart_mmio_ctrl: RTL and testbench
=================================

# uart_mmio_ctrl

Sequencing controller between the CPU data-memory port and the UART when the MMU flags an MMIO access. It decodes the MMIO register offset, stalls the CPU while the UART cannot accept a byte (TX full) or has none to return (RX empty), and issues single-cycle write and pop strobes. It returns zero-extended read data and bounds every wait with a timeout that sets a sticky error flag.

## Interface
- `TIMEOUT`, default 1023: maximum wait-state cycles before an access is abandoned; range 1..65535. The counter is 16 bits wide.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 1: MMIO access valid. Equals the MMU MMIO enable ANDed with the CPU memory-access valid. Held by the CPU while `stall`=1.
- `we` in 1: 1 = store, 0 = load.
- `offset` in 2: register select, equal to physical address bits [3:2].
- `wdata` in 32: store data; only bits [7:0] are used.
- `rdata` out 32: load data, zero-extended.
- `stall` out 1: CPU must hold the current access.
- `tx_full` in 1: UART TX FIFO full.
- `rx_empty` in 1: UART RX FIFO empty.
- `uart_rx_data` in 8: UART RX FIFO head byte.
- `uart_we` out 1: one-cycle TX push strobe.
- `uart_wdata` out 8: TX byte, registered.
- `uart_re` out 1: one-cycle RX pop strobe.
- `err` out 1: sticky timeout flag.

## Operation
- Register map by `offset`:
  - 0 = DATA: store pushes TX, load pops RX.
  - 1 = STATUS: read-only; bit0 = `rx_empty`, bit1 = `tx_full`, bit2 = `err`.
  - 2 = ERR: read bit0 = `err`; storing with `wdata[0]`=1 clears it.
  - 3 = reserved: reads 0, writes ignored.
- STATUS, ERR and reserved accesses complete in the IDLE cycle with no stall. The ERR clear takes effect at that cycle's edge.
- FSM states are IDLE, TX_WAIT, RX_WAIT and DONE.
  - IDLE: on `req` with `offset`=0:
    - Capture `wdata[7:0]` into `uart_wdata`.
    - Clear the counter.
    - Go to TX_WAIT if `we`=1, else RX_WAIT.
    - `stall`=1 in this cycle.
  - TX_WAIT: `stall`=1.
    - If `tx_full`=0: `uart_we`=1 this cycle, then go to DONE.
    - Else increment the counter. When the counter equals `TIMEOUT`, set `err` and go to DONE with no push.
  - RX_WAIT: `stall`=1.
    - If `rx_empty`=0: `uart_re`=1 and latch `uart_rx_data` into `rdata_q`, then go to DONE.
    - On timeout: set `err`, load 0 into `rdata_q`, go to DONE.
  - DONE: `stall`=0 and `rdata`={24'b0, `rdata_q`}. `req` is ignored in this cycle (it is the completing access). Always go to IDLE.
- `uart_we` = (state==TX_WAIT && !`tx_full`). `uart_re` = (state==RX_WAIT && !`rx_empty`). These are combinational on state and flags.
- `stall` = (state==IDLE && `req` && `offset`==0) || state in {TX_WAIT, RX_WAIT}.
- `rdata` outside DONE is the combinational STATUS/ERR/zero value for offsets 1–3, and 0 when `req`=0.
- Reset, including mid-access: state goes to IDLE; counter, `rdata_q`, `uart_wdata` and `err` go to 0. While `reset`=1, all outputs are 0, including `stall`, `uart_we` and `uart_re`. An interrupted push or pop is not performed.

## Timing
- DATA store, UART ready: stall in cycles 0–1, push strobe in cycle 1, completion (`stall`=0) in cycle 2. The same holds for a DATA load with the pop.
- Each wait cycle with the flag blocking adds one stall cycle.
- Worst case: 2 + `TIMEOUT` stall cycles, then DONE.
- Back-to-back DATA accesses: the next access is accepted in the IDLE cycle after DONE. Minimum spacing is 3 cycles per access.
- Exactly one `uart_we` or `uart_re` pulse per DATA access, never both, never on timeout.
- The flag is sampled in the same cycle as the strobe. A flag change in the strobe cycle does not cancel the strobe.

## Structure
- Shared header `mmio_defs.vh` holds:
  - offset constants: `MMIO_DATA`, `MMIO_STATUS`, `MMIO_ERR`;
  - STATUS bit positions;
  - FSM state encodings (2-bit).
- Sub-module `wait_timer` is a 16-bit clear/enable counter with a `hit` output compared against `TIMEOUT`.

## Test plan
- Store 0x000000A5 to offset 0 with `tx_full`=0 → `stall` high for 2 cycles, `uart_we` pulses once in cycle 1 with `uart_wdata`=0xA5, `stall` low in cycle 2.
- Load offset 0 with `rx_empty`=1 for 5 cycles, then 0 with `uart_rx_data`=0x3C → 7 stall cycles, one `uart_re` pulse, `rdata`=0x0000003C in DONE.
- `TIMEOUT`=4, store with `tx_full` held 1 → `err` set after 4 wait cycles, no `uart_we`, `stall` released. Then read STATUS → `rdata`=0x00000006. Then store 1 to offset 2 → `err` cleared.
- Read offset 1 with `rx_empty`=0, `tx_full`=1 → `rdata`=0x00000002 in the same cycle, `stall`=0. Read offset 3 → 0.
- Assert `reset` in TX_WAIT with `tx_full`=1 → immediately `stall`=0 and state IDLE. Releasing `tx_full` later produces no `uart_we`.
- Two consecutive loads with RX data 0x11 then 0x22 → exactly two `uart_re` pulses, returns 0x11 then 0x22, with `req` ignored in each DONE cycle.

Source files
------------

// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared definitions for the UART MMIO controller: register offsets, STATUS bit
// positions, FSM encoding and the STATUS word builder.
package uart_mmio_ctrl_pkg;

    localparam logic [1:0] MMIO_DATA   = 2'd0;
    localparam logic [1:0] MMIO_STATUS = 2'd1;
    localparam logic [1:0] MMIO_ERR    = 2'd2;
    localparam logic [1:0] MMIO_RSVD   = 2'd3;

    localparam int STAT_RX_EMPTY = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_ERR      = 2;

    localparam int TIMER_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TX_WAIT = 2'd1,
        ST_RX_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [31:0] status_word(input logic rx_empty,
                                                input logic tx_full,
                                                input logic err);
        logic [31:0] w;
        w = '0;
        w[STAT_RX_EMPTY] = rx_empty;
        w[STAT_TX_FULL]  = tx_full;
        w[STAT_ERR]      = err;
        return w;
    endfunction

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// CPU data-memory side of the MMIO path.
// Handshake: req is the valid; !stall is the ready. An access completes in the
// cycle where req=1 and stall=0, and the CPU holds req/we/offset/wdata stable
// for as long as stall=1.
interface uart_mmio_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  offset;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;

    modport master (output req, we, offset, wdata, input rdata, stall);
    modport slave  (input req, we, offset, wdata, output rdata, stall);
endinterface

// File: rtl/uart_mmio_ctrl_wait_timer.sv
// Wait-state counter: cleared at the start of an access, advanced per blocked
// cycle, and hit when it reaches the programmed limit.
module uart_mmio_ctrl_wait_timer
    import uart_mmio_ctrl_pkg::*;
#(
    parameter logic [TIMER_W-1:0] LIMIT = 16'd1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == LIMIT);

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Sequences CPU MMIO accesses onto the UART FIFOs: stalls while the UART is not
// ready, issues single-cycle push/pop strobes and bounds each wait with a timeout.
module uart_mmio_ctrl
    import uart_mmio_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    uart_mmio_ctrl_if.slave  bus,
    input  logic             tx_full,
    input  logic             rx_empty,
    input  logic [7:0]       uart_rx_data,
    output logic             uart_we,
    output logic [7:0]       uart_wdata,
    output logic             uart_re,
    output logic             err,
    output state_t           state
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT);

    state_t     state_next;
    logic [7:0] rdata_q;
    logic       timer_clr, timer_en, timer_hit;
    logic       capture, set_err, clr_err, rx_latch, rx_zero;
    logic       unused_wdata;

    assign unused_wdata = ^bus.wdata[31:8];

    uart_mmio_ctrl_wait_timer #(.LIMIT(LIMIT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .en    (timer_en),
        .hit   (timer_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
        capture    = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        rx_latch   = 1'b0;
        rx_zero    = 1'b0;
        uart_we    = 1'b0;
        uart_re    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    if (bus.offset == MMIO_DATA) begin
                        capture    = 1'b1;
                        timer_clr  = 1'b1;
                        state_next = bus.we ? ST_TX_WAIT : ST_RX_WAIT;
                    end else if (bus.offset == MMIO_ERR && bus.we && bus.wdata[0]) begin
                        clr_err = 1'b1;
                    end
                end
            end
            ST_TX_WAIT: begin
                if (!tx_full) begin
                    uart_we    = 1'b1;
                    state_next = ST_DONE;
                end else if (timer_hit) begin
                    set_err    = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_RX_WAIT: begin
                if (!rx_empty) begin
                    uart_re    = 1'b1;
                    rx_latch   = 1'b1;
                    state_next = ST_DONE;
                end else if (timer_hit) begin
                    set_err    = 1'b1;
                    rx_zero    = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_DONE: begin
                // The held req here belongs to the access that is completing.
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_wdata <= '0;
            rdata_q    <= '0;
            err        <= 1'b0;
        end else begin
            if (capture)  uart_wdata <= bus.wdata[7:0];
            if (rx_latch) rdata_q    <= uart_rx_data;
            if (rx_zero)  rdata_q    <= '0;
            if (set_err)       err <= 1'b1;
            else if (clr_err)  err <= 1'b0;
        end
    end

    // Gated with reset so the CPU sees no stall or data while reset is held.
    assign bus.stall = !reset &&
                       ((state == ST_IDLE && bus.req && bus.offset == MMIO_DATA) ||
                        state == ST_TX_WAIT || state == ST_RX_WAIT);

    always_comb begin
        bus.rdata = '0;
        if (reset) begin
            bus.rdata = '0;
        end else if (state == ST_DONE) begin
            bus.rdata = {24'b0, rdata_q};
        end else if (bus.req) begin
            case (bus.offset)
                MMIO_STATUS: bus.rdata = status_word(rx_empty, tx_full, err);
                MMIO_ERR:    bus.rdata = {31'b0, err};
                MMIO_DATA,
                MMIO_RSVD:   bus.rdata = '0;
                default:     bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: one instance at the default timeout, one
// at a short timeout for the error path.
module tb_uart_mmio_ctrl;
    import uart_mmio_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_mmio_ctrl_if bus();
    uart_mmio_ctrl_if bus4();

    logic       tx_full, rx_empty, uart_we, uart_re, err;
    logic [7:0] rx_data, uart_wdata;
    state_t     state;
    logic       tx_full4, rx_empty4, uart_we4, uart_re4, err4;
    logic [7:0] rx_data4, uart_wdata4;
    state_t     state4;

    uart_mmio_ctrl dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .tx_full(tx_full), .rx_empty(rx_empty), .uart_rx_data(rx_data),
        .uart_we(uart_we), .uart_wdata(uart_wdata), .uart_re(uart_re),
        .err(err), .state(state)
    );

    uart_mmio_ctrl #(.TIMEOUT(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave),
        .tx_full(tx_full4), .rx_empty(rx_empty4), .uart_rx_data(rx_data4),
        .uart_we(uart_we4), .uart_wdata(uart_wdata4), .uart_re(uart_re4),
        .err(err4), .state(state4)
    );

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt = 0, re_cnt = 0, we4_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every TX push must match the next expected byte.
    always @(negedge clk) begin
        if (uart_we) begin
            we_cnt++;
            if (exp_q.size() == 0) check("tx_unexpected", exp_q.size(), 1);
            else check("tx_byte", {24'b0, uart_wdata}, {24'b0, exp_q.pop_front()});
        end
        if (uart_re) re_cnt++;
        if (uart_we4 || uart_re4) we4_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req = 1'b0; bus.we = 1'b0; bus.offset = 2'd0; bus.wdata = '0;
    endtask

    // Holds the access until stall drops; returns stall count and rdata at completion.
    task automatic access(input logic w, input logic [1:0] off, input logic [31:0] wd,
                          output int stalls, output logic [31:0] rd);
        bit done;
        bus.req = 1'b1; bus.we = w; bus.offset = off; bus.wdata = wd;
        stalls = 0; done = 0; rd = '0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (bus.stall) begin
                stalls++;
                step();
            end else begin
                done = 1;
                rd = bus.rdata;
            end
        end
        check("access_bound", {31'b0, done}, 32'd1);
        step();
    endtask

    int          st, st4, base;
    logic [31:0] rd;
    bit          done4;

    initial begin
        bus.req = 1'b1; bus.we = 1'b0; bus.offset = MMIO_DATA; bus.wdata = '0;
        bus4.req = 1'b0; bus4.we = 1'b0; bus4.offset = 2'd0; bus4.wdata = '0;
        tx_full = 1'b0; rx_empty = 1'b1; rx_data = 8'h00;
        tx_full4 = 1'b0; rx_empty4 = 1'b1; rx_data4 = 8'h00;

        // Outputs forced quiet while reset is held, even with a DATA request.
        #12;
        check("rst_stall", {31'b0, bus.stall}, 32'd0);
        check("rst_state", {30'b0, state}, {30'b0, ST_IDLE});
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_wdata", {24'b0, uart_wdata}, 32'd0);
        bus.offset = MMIO_STATUS;
        #1 check("rst_rdata", bus.rdata, 32'd0);
        idle();
        @(posedge clk); #1 reset = 1'b0;
        step();

        // Store 0xA5, UART ready: strobe in cycle 1, done in cycle 2.
        exp_q.push_back(8'hA5);
        base = we_cnt;
        bus.req = 1'b1; bus.we = 1'b1; bus.offset = MMIO_DATA; bus.wdata = 32'h0000_00A5;
        @(negedge clk);
        check("t1_c0_stall", {31'b0, bus.stall}, 32'd1);
        check("t1_c0_we", {31'b0, uart_we}, 32'd0);
        step(); @(negedge clk);
        check("t1_c1_stall", {31'b0, bus.stall}, 32'd1);
        check("t1_c1_we", {31'b0, uart_we}, 32'd1);
        check("t1_c1_wdata", {24'b0, uart_wdata}, 32'h0000_00A5);
        step(); @(negedge clk);
        check("t1_c2_stall", {31'b0, bus.stall}, 32'd0);
        check("t1_c2_we", {31'b0, uart_we}, 32'd0);
        check("t1_c2_state", {30'b0, state}, {30'b0, ST_DONE});
        step(); idle(); step();
        check("t1_pushes", we_cnt - base, 32'd1);

        // Store with junk in the upper bits: only the low byte goes out.
        exp_q.push_back(8'hC3);
        access(1'b1, MMIO_DATA, 32'h1234_56C3, st, rd);
        idle();
        check("t1b_stalls", st, 32'd2);

        // Load with RX empty for 5 wait cycles, then 0x3C.
        base = re_cnt;
        fork
            access(1'b0, MMIO_DATA, 32'h0, st, rd);
            begin
                repeat (6) @(posedge clk);
                #1; rx_empty = 1'b0; rx_data = 8'h3C;
                @(posedge clk);
                #1; rx_empty = 1'b1;
            end
        join
        idle();
        check("t2_stalls", st, 32'd7);
        check("t2_rdata", rd, 32'h0000_003C);
        step();
        check("t2_pops", re_cnt - base, 32'd1);

        // STATUS / reserved / ERR reads complete without stall.
        rx_empty = 1'b0; tx_full = 1'b1;
        bus.req = 1'b1; bus.we = 1'b0; bus.offset = MMIO_STATUS;
        @(negedge clk);
        check("t4_status", bus.rdata, 32'h0000_0002);
        check("t4_status_stall", {31'b0, bus.stall}, 32'd0);
        step(); bus.offset = MMIO_RSVD;
        @(negedge clk);
        check("t4_rsvd", bus.rdata, 32'd0);
        step(); bus.offset = MMIO_ERR;
        @(negedge clk);
        check("t4_err_rd", bus.rdata, 32'd0);
        step(); bus.we = 1'b1; bus.offset = MMIO_RSVD; bus.wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("t4_rsvd_wr_stall", {31'b0, bus.stall}, 32'd0);
        step(); bus.req = 1'b0; bus.we = 1'b0; bus.offset = MMIO_STATUS;
        @(negedge clk);
        check("t4_noreq_rdata", bus.rdata, 32'd0);
        check("t4_noreq_stall", {31'b0, bus.stall}, 32'd0);
        step(); idle(); rx_empty = 1'b1;

        // Reset during TX_WAIT: no push afterwards, stall gone at once.
        base = we_cnt;
        bus.req = 1'b1; bus.we = 1'b1; bus.offset = MMIO_DATA; bus.wdata = 32'h77;
        step(); @(negedge clk);
        check("t5_pre_state", {30'b0, state}, {30'b0, ST_TX_WAIT});
        #1 reset = 1'b1;
        #1;
        check("t5_stall", {31'b0, bus.stall}, 32'd0);
        check("t5_state", {30'b0, state}, {30'b0, ST_IDLE});
        check("t5_uwdata", {24'b0, uart_wdata}, 32'd0);
        step(); idle(); reset = 1'b0;
        step(); tx_full = 1'b0;
        repeat (3) step();
        check("t5_no_push", we_cnt - base, 32'd0);

        // Back-to-back loads: 0x11 then 0x22, req held through both DONE cycles.
        base = re_cnt;
        rx_empty = 1'b0; rx_data = 8'h11;
        access(1'b0, MMIO_DATA, 32'h0, st, rd);
        check("t6_stalls_a", st, 32'd2);
        check("t6_rdata_a", rd, 32'h0000_0011);
        rx_data = 8'h22;
        access(1'b0, MMIO_DATA, 32'h0, st, rd);
        idle(); rx_empty = 1'b1;
        check("t6_stalls_b", st, 32'd2);
        check("t6_rdata_b", rd, 32'h0000_0022);
        step();
        check("t6_pops", re_cnt - base, 32'd2);
        check("t6_scoreboard_left", exp_q.size(), 32'd0);

        // Timeout path with TIMEOUT=4: 2+4 stall cycles, err set, no strobe.
        tx_full4 = 1'b1;
        bus4.req = 1'b1; bus4.we = 1'b1; bus4.offset = MMIO_DATA; bus4.wdata = 32'h5A;
        st4 = 0; done4 = 0;
        for (int i = 0; i < 40 && !done4; i++) begin
            @(negedge clk);
            if (bus4.stall) begin st4++; step(); end
            else done4 = 1;
        end
        check("t3_bound", {31'b0, done4}, 32'd1);
        check("t3_stalls", st4, 32'd6);
        check("t3_err", {31'b0, err4}, 32'd1);
        check("t3_no_strobe", we4_cnt, 32'd0);
        step(); rx_empty4 = 1'b0; bus4.we = 1'b0; bus4.offset = MMIO_STATUS;
        @(negedge clk);
        check("t3_status", bus4.rdata, 32'h0000_0006);
        check("t3_status_stall", {31'b0, bus4.stall}, 32'd0);
        step(); bus4.offset = MMIO_ERR;
        @(negedge clk);
        check("t3_err_rd", bus4.rdata, 32'h0000_0001);
        step(); bus4.we = 1'b1; bus4.wdata = 32'h1;
        @(negedge clk);
        check("t3_err_before_edge", {31'b0, err4}, 32'd1);
        step(); bus4.req = 1'b0; bus4.we = 1'b0;
        @(negedge clk);
        check("t3_err_cleared", {31'b0, err4}, 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout got=%0d exp=0", n_checks);
        $fatal(1, "bench time limit");
    end

endmodule
